// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode hex display driver with per-frame input snapshot.
// Optional leading-zero blanking when SEG7_SCAN_LZB_EN is defined.
module seg7_scan_driver #(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic                r_run;
  logic [4*DIGITS-1:0] r_sh_data;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [DIGITS-1:0]   r_sh_blank;
  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_an;
  logic                r_fs;

  logic [3:0]          w_val;
  logic [DIGITS-1:0]   w_lz;
  logic [7:0]          w_seg;
  logic                w_tick;

  function automatic logic [6:0] f_hex7(input logic [3:0] v);
    case (v)
      4'h0: f_hex7 = 7'h40;
      4'h1: f_hex7 = 7'h79;
      4'h2: f_hex7 = 7'h24;
      4'h3: f_hex7 = 7'h30;
      4'h4: f_hex7 = 7'h19;
      4'h5: f_hex7 = 7'h12;
      4'h6: f_hex7 = 7'h02;
      4'h7: f_hex7 = 7'h78;
      4'h8: f_hex7 = 7'h00;
      4'h9: f_hex7 = 7'h18;
      4'hA: f_hex7 = 7'h08;
      4'hB: f_hex7 = 7'h03;
      4'hC: f_hex7 = 7'h46;
      4'hD: f_hex7 = 7'h21;
      4'hE: f_hex7 = 7'h06;
      default: f_hex7 = 7'h0E;
    endcase
  endfunction

  assign w_val  = r_sh_data[4*int'(r_idx) +: 4];
  assign w_tick = (r_cnt == CNT_MAX);

`ifdef SEG7_SCAN_LZB_EN
  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    logic w_zero_above;
    w_lz         = '0;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_above = w_zero_above & (r_sh_data[4*i +: 4] == 4'h0);
      if (i != 0) w_lz[i] = w_zero_above;
    end
  end
`else
  assign w_lz = '0;
`endif

  always_comb begin
    w_seg = 8'hFF;
    if (!r_sh_blank[r_idx]) begin
      if (w_lz[r_idx]) w_seg = {~r_sh_dp[r_idx], 7'h7F};
      else             w_seg = {~r_sh_dp[r_idx], f_hex7(w_val)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_run      <= 1'b0;
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '1;
      r_seg      <= 8'hFF;
      r_an       <= '1;
      r_fs       <= 1'b0;
    end else if (!en) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_run <= 1'b0;
      r_seg <= 8'hFF;
      r_an  <= '1;
      r_fs  <= 1'b0;
    end else if (!r_run) begin
      // First enabled edge: snapshot only; digit 0 appears on the next edge.
      r_run      <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sh_data  <= data;
      r_sh_dp    <= dp;
      r_sh_blank <= blank;
      r_seg      <= 8'hFF;
      r_an       <= '1;
      r_fs       <= 1'b1;
    end else begin
      r_seg <= w_seg;
      r_an  <= ~(DIGITS'(1) << r_idx);
      r_fs  <= 1'b0;
      if (w_tick) begin
        r_cnt <= '0;
        if (r_idx == IDX_MAX) begin
          r_idx      <= '0;
          r_sh_data  <= data;
          r_sh_dp    <= dp;
          r_sh_blank <= blank;
          r_fs       <= 1'b1;
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign seg_out     = r_seg;
  assign an          = r_an;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, DIV=4) against a timeline model.
// Honours SEG7_SCAN_LZB_EN in the reference model as well.
module tb_seg7_scan_driver;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int NF     = DIGITS * DIV;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [7:0]  seg_out;
  logic [3:0]  an;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: snapshot and cycles elapsed since the last snapshot edge.
  logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         m_val [DIGITS];
  logic       m_dp [DIGITS];
  logic       m_blank [DIGITS];
  bit         m_act = 0;
  int         m_t   = 0;

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data), .dp(dp), .blank(blank),
    .seg_out(seg_out), .an(an), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic take_snapshot();
    for (int i = 0; i < DIGITS; i++) begin
      m_val[i]   = int'(data >> (4 * i)) % 16;
      m_dp[i]    = dp[i];
      m_blank[i] = blank[i];
    end
  endtask

  function automatic logic [7:0] shown(input int d);
    bit suppress;
    suppress = 0;
`ifdef SEG7_SCAN_LZB_EN
    if (d != 0) begin
      suppress = 1;
      for (int j = d; j < DIGITS; j++) if (m_val[j] != 0) suppress = 0;
    end
`endif
    if (m_blank[d]) return 8'hFF;
    if (suppress)   return {~m_dp[d], 7'h7F};
    return {~m_dp[d], hex7[m_val[d]]};
  endfunction

  task automatic cyc();
    logic [7:0] es;
    logic [3:0] ea;
    logic       ef;
    int         d;
    @(posedge clk);
    if (!en) begin
      m_act = 0; m_t = 0;
      es = 8'hFF; ea = 4'hF; ef = 1'b0;
    end else if (!m_act) begin
      m_act = 1; m_t = 0;
      take_snapshot();
      es = 8'hFF; ea = 4'hF; ef = 1'b1;
    end else begin
      m_t++;
      d  = (m_t - 1) / DIV;
      es = shown(d);
      ea = 4'hF ^ (4'b0001 << d);
      ef = (m_t == NF);
      if (m_t == NF) begin
        take_snapshot();
        m_t = 0;
      end
    end
    #1;
    chk("seg_out", seg_out, es);
    chk("an", {4'h0, an}, {4'h0, ea});
    chk("frame_start", {7'h0, frame_start}, {7'h0, ef});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    data = d; dp = p; blank = b;
  endtask

  initial begin
    int drop;
    rst_n = 1'b1; en = 1'b0;
    set_in(16'h0000, 4'h0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_seg", seg_out, 8'hFF);
    chk("reset_an", {4'h0, an}, 8'h0F);
    chk("reset_fs", {7'h0, frame_start}, 8'h00);
    @(posedge clk); #3 rst_n = 1'b1;

    run(2);
    en = 1'b1;
    set_in(16'h1234, 4'h0, 4'h0);
    run(20);
    set_in(16'hABCD, 4'h0, 4'h0);
    run(40);
    set_in(16'h5E07, 4'b0010, 4'b1000);
    run(36);

    // Disable for 3 cycles partway through digit 2 of a fresh frame.
    en = 1'b0; run(1);
    set_in(16'h1234, 4'h0, 4'h0);
    en = 1'b1; run(11);
    en = 1'b0; run(3);
    en = 1'b1; run(20);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", seg_out, 8'hFF);
    chk("async_an", {4'h0, an}, 8'h0F);
    chk("async_fs", {7'h0, frame_start}, 8'h00);
    m_act = 0; m_t = 0;
    #2 rst_n = 1'b1;
    run(20);

    set_in(16'h0050, 4'h0, 4'h0);
    run(34);
    set_in(16'h0000, 4'h0, 4'h0);
    run(34);
    set_in(16'h0900, 4'b0100, 4'h0);
    run(34);

    drop = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) data = 16'($urandom);
      if ($urandom_range(7) == 0) data = ($urandom_range(1) == 0) ? 16'h0000 : 16'($urandom_range(255));
      if ($urandom_range(15) == 0) dp = 4'($urandom);
      if ($urandom_range(15) == 0) blank = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
      if (drop > 0) begin
        drop--;
        if (drop == 0) en = 1'b1;
      end else if ($urandom_range(49) == 0) begin
        en = 1'b0;
        drop = $urandom_range(1, 3);
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
